// File: rtl/reg_mem_dp.sv
// Register memory with one byte-enabled write port, two registered read ports and a
// clear engine that zeroes every location after reset or on request.
module reg_mem_dp #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 6,
   parameter int RDW_MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [ADDR_BITS-1:0]    wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en_a,
   input  logic [ADDR_BITS-1:0]    rd_addr_a,
   input  logic                    rd_en_b,
   input  logic [ADDR_BITS-1:0]    rd_addr_b,
   output logic [DATA_WIDTH-1:0]   rd_data_a,
   output logic [DATA_WIDTH-1:0]   rd_data_b,
   output logic                    rd_valid_a,
   output logic                    rd_valid_b,
   input  logic                    clr_req,
   output logic                    busy,
   output logic                    wr_err
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_BITS-1:0]  r_cnt;
   logic [ADDR_BITS-1:0]  w_cnt_next;
   logic                  r_busy;
   logic                  r_wr_err;
   logic [DATA_WIDTH-1:0] r_rd_data_a;
   logic [DATA_WIDTH-1:0] r_rd_data_b;
   logic                  r_rd_valid_a;
   logic                  r_rd_valid_b;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_ready;
   logic                  w_wr_accept;
   logic                  w_wr_refuse;
   logic                  w_hit_a;
   logic                  w_hit_b;
   logic [DATA_WIDTH-1:0] w_old_a;
   logic [DATA_WIDTH-1:0] w_old_b;
   logic [DATA_WIDTH-1:0] w_rd_word_a;
   logic [DATA_WIDTH-1:0] w_rd_word_b;

   assign w_ready     = (r_state == S_READY);
   // A clear request on a READY edge takes priority over a simultaneous write.
   assign w_wr_accept = w_ready && wr_en && !clr_req;
   assign w_wr_refuse = wr_en && (!w_ready || clr_req);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_CLEAR: begin
            w_cnt_next = r_cnt + ADDR_BITS'(1);
            if (r_cnt == LAST_ADDR) begin
               w_state_next = S_READY;
            end
         end
         S_READY: begin
            if (clr_req) begin
               w_state_next = S_CLEAR;
               w_cnt_next   = '0;
            end
         end
         default: begin
            w_state_next = S_CLEAR;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Storage has no reset; the clear engine owns initialisation.
   always_ff @(posedge clk) begin
      if (!w_ready) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_accept) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
               r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   assign w_old_a = r_mem[rd_addr_a];
   assign w_old_b = r_mem[rd_addr_b];
   assign w_hit_a = (RDW_MODE != 0) && w_wr_accept && (wr_addr == rd_addr_a);
   assign w_hit_b = (RDW_MODE != 0) && w_wr_accept && (wr_addr == rd_addr_b);

   // Bypass merges per lane so only enabled bytes take the incoming data.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_rd_word_a[8*gi +: 8] = (w_hit_a && wr_be[gi]) ? wr_data[8*gi +: 8]
                                                                : w_old_a[8*gi +: 8];
         assign w_rd_word_b[8*gi +: 8] = (w_hit_b && wr_be[gi]) ? wr_data[8*gi +: 8]
                                                                : w_old_b[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_CLEAR;
         r_cnt        <= '0;
         r_busy       <= 1'b1;
         r_wr_err     <= 1'b0;
         r_rd_data_a  <= '0;
         r_rd_data_b  <= '0;
         r_rd_valid_a <= 1'b0;
         r_rd_valid_b <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_busy       <= (w_state_next == S_CLEAR);
         r_wr_err     <= w_wr_refuse;
         r_rd_valid_a <= w_ready && rd_en_a;
         r_rd_valid_b <= w_ready && rd_en_b;
         if (w_ready && rd_en_a) begin
            r_rd_data_a <= w_rd_word_a;
         end
         if (w_ready && rd_en_b) begin
            r_rd_data_b <= w_rd_word_b;
         end
      end
   end

   assign rd_data_a  = r_rd_data_a;
   assign rd_data_b  = r_rd_data_b;
   assign rd_valid_a = r_rd_valid_a;
   assign rd_valid_b = r_rd_valid_b;
   assign busy       = r_busy;
   assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_reg_mem_dp.sv
// Bench for reg_mem_dp: a default 8-bit old-data instance and a 32-bit bypass instance
// driven in lockstep, with read/error events checked through a cycle-tagged scoreboard.
module tb_reg_mem_dp;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, rd_en_a, rd_en_b, clr_req;
   logic [5:0]  wr_addr, rd_addr_a, rd_addr_b;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;

   logic [7:0]  a8_data, b8_data;
   logic [31:0] a32_data, b32_data;
   logic        a8_v, b8_v, a32_v, b32_v, busy8, busy32, err8, err32;

   always #5 clk = ~clk;

   reg_mem_dp dut8 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(a8_data), .rd_data_b(b8_data), .rd_valid_a(a8_v), .rd_valid_b(b8_v),
      .clr_req(clr_req), .busy(busy8), .wr_err(err8)
   );

   reg_mem_dp #(.DATA_WIDTH(32), .ADDR_BITS(6), .RDW_MODE(1)) dut32 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(a32_data), .rd_data_b(b32_data), .rd_valid_a(a32_v), .rd_valid_b(b32_v),
      .clr_req(clr_req), .busy(busy32), .wr_err(err32)
   );

   // Event ports: 0=A8 1=B8 2=A32 3=B32 4=err8 5=err32
   typedef struct {
      int          port;
      int unsigned tag;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic        we;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        rea;
      logic [5:0]  ra;
      logic        reb;
      logic [5:0]  rb;
      logic [7:0]  ea8;
      logic [7:0]  eb8;
      logic [31:0] ea32;
      logic [31:0] eb32;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[14];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        act_v[6];
   logic [31:0] act_d[4];

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      act_v[0] = a8_v;  act_v[1] = b8_v;  act_v[2] = a32_v;
      act_v[3] = b32_v; act_v[4] = err8;  act_v[5] = err32;
      act_d[0] = {24'b0, a8_data};
      act_d[1] = {24'b0, b8_data};
      act_d[2] = a32_data;
      act_d[3] = b32_data;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic expect_ev(input int port, input logic [31:0] d);
      exp_t e;
      e.port = port;
      e.tag  = cyc + 1;
      e.data = d;
      sb.push_back(e);
   endtask

   // Every cycle, each event port must pulse exactly when the scoreboard expects it.
   always @(negedge clk) begin
      int idx;
      for (int p = 0; p < 6; p++) begin
         idx = -1;
         for (int i = 0; i < sb.size(); i++)
            if (sb[i].port == p && sb[i].tag == cyc) idx = i;
         chk($sformatf("pulse_p%0d_cyc%0d", p, cyc), {31'b0, act_v[p]},
             (idx >= 0) ? 32'd1 : 32'd0);
         if (idx >= 0) begin
            if (p < 4 && act_v[p])
               chk($sformatf("data_p%0d_cyc%0d", p, cyc), act_d[p], sb[idx].data);
            sb.delete(idx);
         end
      end
   end

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0; clr_req = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic rea, input logic [5:0] ra,
                        input logic reb, input logic [5:0] rb, input logic clr);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb; clr_req = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic expect_reads(input logic rea, input logic reb, input logic [31:0] ea,
                               input logic [31:0] eb);
      if (rea) begin expect_ev(0, {24'b0, ea[7:0]}); expect_ev(2, ea); end
      if (reb) begin expect_ev(1, {24'b0, eb[7:0]}); expect_ev(3, eb); end
   endtask

   task automatic count_busy(input string name);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while ((busy8 || busy32) && k < 200);
      chk(name, k, 64);
   endtask

   task automatic read_all_zero();
      for (int i = 0; i < 64; i++) begin
         drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'(i), 1'b1, 6'(63 - i), 1'b0);
         expect_reads(1'b1, 1'b1, 32'h0, 32'h0);
         tick();
      end
      tick();
   endtask

   function automatic logic [31:0] pat(input int a);
      return 32'(32'h01010101 * 32'(a + 1));
   endfunction

   initial begin
      logic [31:0] p;
      int k;
      idle();
      rst_n = 1'b0;
      //          we    wa     wd            be    rea   ra     reb   rb     ea8    eb8    ea32          eb32
      tbl[0]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd0,  1'b1, 6'd31, 8'h00, 8'h00, 32'h0,        32'h0};
      tbl[1]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd63, 1'b1, 6'd63, 8'h00, 8'h00, 32'h0,        32'h0};
      tbl[2]  = '{1'b1, 6'd10, 32'h123456A5, 4'hF, 1'b0, 6'd0,  1'b0, 6'd0,  8'h00, 8'h00, 32'h0,        32'h0};
      tbl[3]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd10, 1'b1, 6'd11, 8'hA5, 8'h00, 32'h123456A5, 32'h0};
      tbl[4]  = '{1'b1, 6'd20, 32'h11223344, 4'hF, 1'b0, 6'd0,  1'b0, 6'd0,  8'h00, 8'h00, 32'h0,        32'h0};
      tbl[5]  = '{1'b1, 6'd20, 32'hAABBCCDD, 4'h5, 1'b1, 6'd20, 1'b1, 6'd20, 8'h44, 8'h44, 32'h11BB33DD, 32'h11BB33DD};
      tbl[6]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd20, 1'b1, 6'd20, 8'hDD, 8'hDD, 32'h11BB33DD, 32'h11BB33DD};
      tbl[7]  = '{1'b1, 6'd5,  32'h0000003C, 4'hF, 1'b0, 6'd0,  1'b0, 6'd0,  8'h00, 8'h00, 32'h0,        32'h0};
      tbl[8]  = '{1'b1, 6'd5,  32'h000000C3, 4'h1, 1'b1, 6'd5,  1'b1, 6'd6,  8'h3C, 8'h00, 32'h000000C3, 32'h0};
      tbl[9]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd5,  1'b1, 6'd5,  8'hC3, 8'hC3, 32'h000000C3, 32'h000000C3};
      tbl[10] = '{1'b1, 6'd5,  32'hFFFFFFFF, 4'h0, 1'b1, 6'd5,  1'b1, 6'd5,  8'hC3, 8'hC3, 32'h000000C3, 32'h000000C3};
      tbl[11] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd5,  1'b1, 6'd10, 8'hC3, 8'hA5, 32'h000000C3, 32'h123456A5};
      tbl[12] = '{1'b1, 6'd7,  32'h0000AA55, 4'h2, 1'b1, 6'd7,  1'b1, 6'd7,  8'h00, 8'h00, 32'h0000AA00, 32'h0000AA00};
      tbl[13] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd7,  1'b1, 6'd20, 8'h00, 8'hDD, 32'h0000AA00, 32'h11BB33DD};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy8", {31'b0, busy8}, 32'd1);
      chk("rst_busy32", {31'b0, busy32}, 32'd1);
      chk("rst_rd_data_a32", a32_data, 32'h0);
      chk("rst_rd_data_b32", b32_data, 32'h0);
      chk("rst_rd_data_a8", {24'b0, a8_data}, 32'h0);
      rst_n = 1'b1;
      count_busy("busy_edges_after_reset");

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].rea, tbl[i].ra,
               tbl[i].reb, tbl[i].rb, 1'b0);
         if (tbl[i].rea) begin expect_ev(0, {24'b0, tbl[i].ea8}); expect_ev(2, tbl[i].ea32); end
         if (tbl[i].reb) begin expect_ev(1, {24'b0, tbl[i].eb8}); expect_ev(3, tbl[i].eb32); end
         tick();
      end

      // Fill every address, reading back the previous one on port A.
      for (int a = 0; a < 64; a++) begin
         drive(1'b1, 6'(a), pat(a), 4'hF, a > 0, 6'(a - 1), 1'b0, 6'd0, 1'b0);
         if (a > 0) begin
            p = pat(a - 1);
            expect_ev(0, {24'b0, p[7:0]});
            expect_ev(2, p);
         end
         tick();
      end

      // Clear request with a simultaneous write: write dropped, reads use pre-clear data.
      drive(1'b1, 6'd0, 32'hDEADBEEF, 4'hF, 1'b1, 6'd3, 1'b1, 6'd0, 1'b1);
      expect_reads(1'b1, 1'b1, pat(3), pat(0));
      expect_ev(4, 32'h0);
      expect_ev(5, 32'h0);
      tick();
      chk("clr_busy_high", {31'b0, busy8}, 32'd1);
      k = 0;
      do begin
         if (k == 10) begin
            drive(1'b1, 6'd1, 32'h99999999, 4'hF, 1'b1, 6'd1, 1'b1, 6'd2, 1'b1);
            expect_ev(4, 32'h0);
            expect_ev(5, 32'h0);
         end
         tick();
         k++;
      end while (busy8 && k < 200);
      chk("clr_busy_edges", k, 64);
      chk("clr_busy32_low", {31'b0, busy32}, 32'd0);
      chk("hold_rd_data_a32", a32_data, pat(3));
      p = pat(0);
      chk("hold_rd_data_b8", {24'b0, b8_data}, {24'b0, p[7:0]});
      read_all_zero();

      // Reset in the middle of a clear.
      drive(1'b1, 6'd40, 32'h77777777, 4'hF, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      tick();
      drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd40, 1'b1, 6'd40, 1'b0);
      expect_reads(1'b1, 1'b1, 32'h77777777, 32'h77777777);
      tick();
      drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
      tick();
      repeat (20) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy8", {31'b0, busy8}, 32'd1);
      chk("midrst_busy32", {31'b0, busy32}, 32'd1);
      chk("midrst_valid_a32", {31'b0, a32_v}, 32'd0);
      chk("midrst_rd_data_a8", {24'b0, a8_data}, 32'h0);
      chk("midrst_rd_data_b32", b32_data, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_busy("busy_edges_after_midclear_reset");
      read_all_zero();

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule

// File: doc/reg_mem_dp.md
# reg_mem_dp

Parametrised successor to the single-port register memory: one byte-enabled write port, two independent registered read ports, a selectable read-during-write policy, and a built-in clear engine that zeroes every location after reset or on request. It is the general-purpose scratch and lookup store for datapath blocks that need concurrent reads, for example operand fetch alongside result writeback. All accesses are synchronous to one clock. Contents are guaranteed zero before first use.

## Interface
- `DATA_WIDTH`, 8: word width in bits; must be a multiple of 8.
- `ADDR_BITS`, 6: address width; DEPTH = 2**ADDR_BITS locations.
- `RDW_MODE`, 0: same-address read-during-write policy; 0 = old data, 1 = new data (bypass).
- Derived: LANES = DATA_WIDTH/8.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write request.
- `wr_addr` in ADDR_BITS: write address.
- `wr_data` in DATA_WIDTH: write data.
- `wr_be` in LANES: byte enables; bit i selects bits [8i+7:8i].
- `rd_en_a`, `rd_en_b` in 1: read requests, ports A and B.
- `rd_addr_a`, `rd_addr_b` in ADDR_BITS: read addresses.
- `rd_data_a`, `rd_data_b` out DATA_WIDTH: registered read data.
- `rd_valid_a`, `rd_valid_b` out 1: read data valid, one-cycle pulse per accepted read.
- `clr_req` in 1: request a full clear (level sampled each edge).
- `busy` out 1: clear engine active; all accesses are refused while high.
- `wr_err` out 1: one-cycle pulse when a write is refused because `busy` is high.

## Operation
- FSM states: CLEAR and READY.
  - Reset forces CLEAR with clear counter = 0.
  - In CLEAR, each edge writes 0 to mem[counter], then increments the counter.
  - On the edge that writes DEPTH-1, the FSM moves to READY and the counter wraps to 0.
  - In READY, `clr_req`=1 moves the FSM to CLEAR with counter 0.
  - `clr_req` is ignored while in CLEAR; the clear does not restart.
- `busy` = 1 in CLEAR, 0 in READY, registered.
- Write, READY only:
  - On an edge with `wr_en`=1, each lane with `wr_be`[i]=1 is updated.
  - Lanes with `wr_be`[i]=0 keep their old value.
  - `wr_be`=0 writes nothing and raises no error.
- Write while `busy`=1: memory is untouched, and `wr_err`=1 for the next cycle.
- Read, per port, READY only:
  - `rd_en`=1 registers mem[addr] into `rd_data` and sets `rd_valid`=1 for one cycle.
  - With `rd_en`=0, or while busy, `rd_valid`=0 and `rd_data` holds its last value.
  - Unlike the previous generation, a write does not zero the read outputs.
- Read-during-write, same edge, same address:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, with enabled lanes from `wr_data` and other lanes from the old word.
  - Ports A and B resolve this independently. A and B may read the same address.
- Different addresses never interact.
- `clr_req` and `wr_en` on the same READY edge: the clear wins, the write is dropped, and `wr_err` pulses.
- A read on that same edge is still serviced with pre-clear data.

## Timing
- Reset values: `rd_data_a`/`rd_data_b` = 0, `rd_valid_a`/`rd_valid_b` = 0, `busy` = 1, `wr_err` = 0, FSM = CLEAR, counter = 0.
- Memory array contents are not reset directly; the clear engine zeroes them.
- After `rst_n` rises, `busy` stays high for exactly DEPTH rising edges. The first access is accepted on edge DEPTH+1.
- A `clr_req` accepted at edge N makes `busy` high after N. Clear writes occur on edges N+1 through N+DEPTH. `busy` falls after edge N+DEPTH.
- Read latency is 1 cycle: address at edge N gives data and valid after edge N.
- A write at edge N is visible to a read issued at edge N+1, or at edge N when RDW_MODE=1.
- `wr_err` is asserted the cycle after the refused write.
- Reset asserted mid-clear or mid-access:
  - Outputs return to reset values immediately (asynchronously).
  - The clear restarts from address 0 after release.

## Test plan
- Post-reset clear:
  - Release `rst_n`. `busy` is high for exactly 64 edges (default params), then low.
  - Reads of addresses 0, 31 and 63 on ports A and B all return 0x00 with `rd_valid`=1.
- Write then read:
  - Write 0xA5 to address 10.
  - Next cycle, read address 10 on A and address 11 on B: A returns 0xA5, B returns 0x00. Both valids pulse for one cycle.
- Byte enables (DATA_WIDTH=32):
  - Write 0x11223344 with be=1111, then 0xAABBCCDD with be=0101 to the same address.
  - A read returns 0x11BB33DD.
- Read-during-write:
  - Address 5 holds 0x3C. Write 0xC3 to 5 and read 5 on A on the same edge.
  - RDW_MODE=0 returns 0x3C. RDW_MODE=1 returns 0xC3.
  - A read of 5 on the next cycle returns 0xC3 in both modes.
- Clear request:
  - Fill addresses 0–63 with nonzero data, then pulse `clr_req` together with a write.
  - Required: `wr_err` pulses, `busy` is high for 64 cycles, and a write during busy gives `wr_err` with no memory change.
  - Afterwards all locations read 0x00.
- Reset mid-clear:
  - Assert `rst_n` low at clear address 20. `busy`=1 and `rd_valid`=0 immediately.
  - After release, `busy` is high for a full 64 edges and all locations read zero.
